// File: rtl/alu_serial_seq_if.sv
// Handshake and result bundle between the control FSM (master) and the
// bit-serial ALU (slave). Optional abort line under ALU_SERIAL_ABORT_EN.
interface alu_serial_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;
`ifdef ALU_SERIAL_ABORT_EN
    logic             abort;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, result, carryout, overflow, zero
    );
    modport slave (
        input  start, op, a, b, abort,
        output busy, done, result, carryout, overflow, zero
    );
`else
    modport master (
        output start, op, a, b,
        input  busy, done, result, carryout, overflow, zero
    );
    modport slave (
        input  start, op, a, b,
        output busy, done, result, carryout, overflow, zero
    );
`endif
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one bit per cycle, LSB first, WIDTH+1 cycles/op.
// Ports: clk, rst_n (async low), bus (slave: start/op/a/b in, busy/done/
// result/carryout/overflow/zero out). Macro ALU_SERIAL_ABORT_EN adds abort.
module alu_serial_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_serial_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             cy;
    logic             zacc;

    logic [WIDTH-1:0] res_q;
    logic             co_q;
    logic             ov_q;
    logic             z_q;

    logic             inv;
    logic             bi;
    logic             sum;
    logic             cnext;
    logic             sbit;
    logic             slt_bit;
    logic [WIDTH-1:0] word;
    logic             co_f;
    logic             ov_f;
    logic             z_f;
    logic             accept;
    logic             abort_run;

`ifdef ALU_SERIAL_ABORT_EN
    assign abort_run = bus.abort;
`else
    assign abort_run = 1'b0;
`endif

    assign accept = bus.start && (state != RUN);

    // One-bit slice plus the word-level view used on the final bit
    always_comb begin
        inv   = (op_q == OP_SUB) || (op_q == OP_SLT);
        bi    = b_sh[0] ^ inv;
        sum   = a_sh[0] ^ bi ^ cy;
        cnext = (a_sh[0] & bi) | (a_sh[0] & cy) | (bi & cy);
        sbit  = 1'b0;
        unique case (op_q)
            OP_ADD:  sbit = sum;
            OP_SUB:  sbit = sum;
            OP_SLT:  sbit = sum;
            OP_XOR:  sbit = a_sh[0] ^ b_sh[0];
            OP_AND:  sbit = a_sh[0] & b_sh[0];
            OP_NAND: sbit = ~(a_sh[0] & b_sh[0]);
            OP_NOR:  sbit = ~(a_sh[0] | b_sh[0]);
            OP_OR:   sbit = a_sh[0] | b_sh[0];
            default: sbit = 1'b0;
        endcase
        // On the MSB cycle cy is the carry into the MSB
        slt_bit = sum ^ (cy ^ cnext);
        word    = {sbit, r_sh[WIDTH-1:1]};
        co_f    = 1'b0;
        ov_f    = 1'b0;
        z_f     = ~(zacc | sbit);
        if (op_q == OP_SLT) begin
            word = {{(WIDTH-1){1'b0}}, slt_bit};
            z_f  = ~slt_bit;
        end else if (op_q == OP_ADD || op_q == OP_SUB) begin
            co_f = cnext;
            ov_f = cy ^ cnext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            op_q  <= '0;
            cnt   <= '0;
            cy    <= 1'b0;
            zacc  <= 1'b0;
            res_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (abort_run) begin
                        state <= IDLE;
                    end else begin
                        a_sh <= a_sh >> 1;
                        b_sh <= b_sh >> 1;
                        r_sh <= word;
                        cnt  <= cnt + CNT_W'(1);
                        cy   <= cnext;
                        zacc <= zacc | sbit;
                        if (cnt == LAST) begin
                            state <= DONE;
                            res_q <= word;
                            co_q  <= co_f;
                            ov_q  <= ov_f;
                            z_q   <= z_f;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    if (accept) begin
                        state <= RUN;
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        r_sh  <= '0;
                        op_q  <= bus.op;
                        cnt   <= '0;
                        cy    <= (bus.op == OP_SUB) || (bus.op == OP_SLT);
                        zacc  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.result   = res_q;
    assign bus.carryout = co_q;
    assign bus.overflow = ov_q;
    assign bus.zero     = z_q;

endmodule
